multiport_regfile: RTL and testbench

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/multiport_regfile.sv | 149 ++++++++++++++
 tb/tb_multiport_regfile.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_regfile.sv
// multiport_regfile: register file with NRD combinational read ports, two
// byte-masked write ports, a per-entry busy scoreboard, and a registered
// write log.
//
// Ports
//   clk, reset          rising-edge clock; synchronous active-high reset
//   rd_addr / rd_data   NRD packed read addresses / combinational read data
//   rd_busy             scoreboard busy flag per read port
//   we*/wa*/wd*/wbe*    write ports 0 and 1 (enable, address, data, byte enables)
//   wpc*                PC tag of the writer, only copied into the log
//   rsv_en / rsv_addr   reserve request: marks rsv_addr busy
//   log_valid/pc/addr/data  per-port write log, one cycle after the write
//   collision           both ports wrote the same entry in the previous cycle
module multiport_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [DATA_W/8-1:0]      wbe0,
  input  logic [31:0]              wpc0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [DATA_W/8-1:0]      wbe1,
  input  logic [31:0]              wpc1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [1:0]               log_valid,
  output logic [63:0]              log_pc,
  output logic [2*ADDR_W-1:0]      log_addr,
  output logic [2*DATA_W-1:0]      log_data,
  output logic                     collision
);

  localparam int unsigned NBYTE = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              eff0;
  logic              eff1;
  logic              rsv_eff;
  logic [DATA_W-1:0] wv0;
  logic [DATA_W-1:0] wv1;

  always_comb begin
    eff0    = we0 && (wbe0 != '0) && !((ZERO_REG != 0) && (wa0 == '0));
    eff1    = we1 && (wbe1 != '0) && !((ZERO_REG != 0) && (wa1 == '0));
    rsv_eff = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
  end

  // Post-write value of entry a: port 0 bytes first, port 1 overlays its
  // enabled bytes, so a same-address pair yields one merged value.
  function automatic logic [DATA_W-1:0] merged(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = mem[a];
    for (int unsigned b = 0; b < NBYTE; b++) begin
      if (eff0 && (wa0 == a) && wbe0[b]) v[8*b +: 8] = wd0[8*b +: 8];
      if (eff1 && (wa1 == a) && wbe1[b]) v[8*b +: 8] = wd1[8*b +: 8];
    end
    return v;
  endfunction

  always_comb begin
    wv0 = merged(wa0);
    wv1 = merged(wa1);
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              hit;
    ra      = '0;
    hit     = 1'b0;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra  = rd_addr[k*ADDR_W +: ADDR_W];
      hit = (eff0 && (wa0 == ra)) || (eff1 && (wa1 == ra));
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end else if ((BYPASS != 0) && hit) begin
        rd_data[k*DATA_W +: DATA_W] = merged(ra);
        // A same-cycle reserve keeps the stored busy state visible.
        rd_busy[k] = (rsv_eff && (rsv_addr == ra)) ? busy[ra] : 1'b0;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem[ra];
        rd_busy[k]                  = busy[ra];
      end
    end
  end

  // Reserve is applied after the write clears so it wins on the same entry.
  always_comb begin
    busy_nxt = busy;
    if (eff0)    busy_nxt[wa0]      = 1'b0;
    if (eff1)    busy_nxt[wa1]      = 1'b0;
    if (rsv_eff) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (eff0) mem[wa0] <= wv0;
      if (eff1) mem[wa1] <= wv1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      log_valid <= '0;
      log_pc    <= '0;
      log_addr  <= '0;
      log_data  <= '0;
      collision <= 1'b0;
    end else begin
      log_valid <= {eff1, eff0};
      collision <= eff0 && eff1 && (wa0 == wa1);
      if (eff0) begin
        log_pc[31:0]          <= wpc0;
        log_addr[ADDR_W-1:0]  <= wa0;
        log_data[DATA_W-1:0]  <= wv0;
      end
      if (eff1) begin
        log_pc[63:32]              <= wpc1;
        log_addr[2*ADDR_W-1:ADDR_W] <= wa1;
        log_data[2*DATA_W-1:DATA_W] <= wv1;
      end
    end
  end

endmodule

// File: tb/tb_multiport_regfile.sv
module tb_multiport_regfile;

  logic        clk;
  logic        reset;
  logic [14:0] rd_addr;
  logic [95:0] rd_data, rd_data_nb;
  logic [2:0]  rd_busy, rd_busy_nb;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [3:0]  wbe0, wbe1;
  logic [31:0] wpc0, wpc1;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [1:0]  log_valid, log_valid_nb;
  logic [63:0] log_pc, log_pc_nb;
  logic [9:0]  log_addr, log_addr_nb;
  logic [63:0] log_data, log_data_nb;
  logic        collision, collision_nb;

  multiport_regfile #(.DATA_W(32), .ADDR_W(5), .NRD(3), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .wbe0(wbe0), .wpc0(wpc0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .wbe1(wbe1), .wpc1(wpc1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .log_valid(log_valid), .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data),
    .collision(collision));

  multiport_regfile #(.DATA_W(32), .ADDR_W(5), .NRD(3), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .we0(we0), .wa0(wa0), .wd0(wd0), .wbe0(wbe0), .wpc0(wpc0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .wbe1(wbe1), .wpc1(wpc1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .log_valid(log_valid_nb), .log_pc(log_pc_nb), .log_addr(log_addr_nb), .log_data(log_data_nb),
    .collision(collision_nb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic [1:0]  m_lv;
  logic [63:0] m_pc;
  logic [9:0]  m_la;
  logic [63:0] m_ld;
  logic        m_col;

  typedef struct {
    logic [1:0]  lv;
    logic [63:0] pc;
    logic [9:0]  la;
    logic [63:0] ld;
    logic        col;
  } exp_t;
  exp_t sbq[$];

  function automatic logic eff(input logic we, input logic [4:0] wa, input logic [3:0] wbe);
    return we && (wbe != 4'h0) && (wa != 5'd0);
  endfunction

  function automatic logic hit(input logic [4:0] a);
    return (eff(we0, wa0, wbe0) && wa0 == a) || (eff(we1, wa1, wbe1) && wa1 == a);
  endfunction

  function automatic logic [31:0] m_merged(input logic [4:0] a);
    logic [31:0] v;
    logic [31:0] old;
    old = m_mem[a];
    v = old;
    for (int b = 0; b < 4; b++) begin
      if (eff(we1, wa1, wbe1) && wa1 == a && wbe1[b]) v[8*b +: 8] = wd1[8*b +: 8];
      else if (eff(we0, wa0, wbe0) && wa0 == a && wbe0[b]) v[8*b +: 8] = wd0[8*b +: 8];
      else v[8*b +: 8] = old[8*b +: 8];
    end
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic byp);
    if (a == 5'd0) return 32'h0;
    if (byp && hit(a)) return m_merged(a);
    return m_mem[a];
  endfunction

  function automatic logic m_rbusy(input logic [4:0] a);
    logic b;
    if (a == 5'd0) return 1'b0;
    b = m_busy[a];
    if (hit(a) && !(rsv_en && rsv_addr == a)) b = 1'b0;
    return b;
  endfunction

  task automatic model_step();
    exp_t e;
    logic e0, e1;
    logic [31:0] v0, v1;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_busy = 32'h0; m_lv = 2'b00; m_pc = 64'h0; m_la = 10'h0; m_ld = 64'h0; m_col = 1'b0;
    end else begin
      e0 = eff(we0, wa0, wbe0);
      e1 = eff(we1, wa1, wbe1);
      v0 = m_merged(wa0);
      v1 = m_merged(wa1);
      m_lv  = {e1, e0};
      m_col = e0 && e1 && (wa0 == wa1);
      if (e0) begin m_pc[31:0] = wpc0; m_la[4:0] = wa0; m_ld[31:0] = v0; m_mem[wa0] = v0; end
      if (e1) begin m_pc[63:32] = wpc1; m_la[9:5] = wa1; m_ld[63:32] = v1; m_mem[wa1] = v1; end
      if (e0) m_busy[wa0] = 1'b0;
      if (e1) m_busy[wa1] = 1'b0;
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    end
    e.lv = m_lv; e.pc = m_pc; e.la = m_la; e.ld = m_ld; e.col = m_col;
    sbq.push_back(e);
  endtask

  // One clock: combinational checks at the falling edge, then registered
  // checks just after the rising edge against the scoreboard entry.
  task automatic do_cycle(input logic use_tbl, input logic [31:0] t_rd0, input logic t_b0);
    exp_t e;
    logic [4:0] a;
    @(negedge clk);
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        a = rd_addr[k*5 +: 5];
        check($sformatf("rd_data[%0d]", k), 64'(rd_data[k*32 +: 32]), 64'(m_read(a, 1'b1)));
        check($sformatf("rd_busy[%0d]", k), 64'(rd_busy[k]), 64'(m_rbusy(a)));
      end
      check("rd_data_nobypass[0]", 64'(rd_data_nb[31:0]), 64'(m_read(rd_addr[4:0], 1'b0)));
    end
    if (use_tbl) begin
      check("tbl_rd_data0", 64'(rd_data[31:0]), 64'(t_rd0));
      check("tbl_rd_busy0", 64'(rd_busy[0]), 64'(t_b0));
    end
    model_step();
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      check("log_valid", 64'(log_valid), 64'(e.lv));
      check("log_pc",    log_pc,         e.pc);
      check("log_addr",  64'(log_addr),  64'(e.la));
      check("log_data",  log_data,       e.ld);
      check("collision", 64'(collision), 64'(e.col));
    end
  endtask

  typedef struct {
    logic        rst;
    logic        we0; logic [4:0] wa0; logic [31:0] wd0; logic [3:0] wbe0; logic [31:0] wpc0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1; logic [3:0] wbe1; logic [31:0] wpc1;
    logic        rsv; logic [4:0] raddr;
    logic [4:0]  ra0; logic [4:0] ra1; logic [4:0] ra2;
    logic [31:0] exp_rd0;
    logic        exp_b0;
  } vec_t;

  vec_t tbl [23];

  task automatic apply(input vec_t v);
    reset = v.rst;
    we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0; wbe0 = v.wbe0; wpc0 = v.wpc0;
    we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1; wbe1 = v.wbe1; wpc1 = v.wpc1;
    rsv_en = v.rsv; rsv_addr = v.raddr;
    rd_addr = {v.ra2, v.ra1, v.ra0};
  endtask

  initial begin
    //           rst   we0  wa0   wd0           wbe0  wpc0          we1  wa1   wd1           wbe1  wpc1          rsv  raddr  ra0   ra1   ra2    exp_rd0       b0
    tbl[0]  = '{1'b0, 1'b1,5'd3, 32'hDEADBEEF,4'hF,32'h00003000, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd3,5'd5,5'd0,  32'hDEADBEEF,1'b0};
    tbl[1]  = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd3,5'd3,5'd0,  32'hDEADBEEF,1'b0};
    tbl[2]  = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b1,5'd5, 32'h11223344,4'hF,32'h00003004, 1'b0,5'd0,  5'd5,5'd3,5'd5,  32'h11223344,1'b0};
    tbl[3]  = '{1'b0, 1'b1,5'd5, 32'hAABBCC88,4'h3,32'h00003008, 1'b1,5'd5, 32'h55667788,4'h2,32'h0000300C, 1'b0,5'd0,  5'd5,5'd3,5'd5,  32'h11227788,1'b0};
    tbl[4]  = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd5,5'd7,5'd0,  32'h11227788,1'b0};
    tbl[5]  = '{1'b0, 1'b1,5'd7, 32'h12345678,4'hF,32'h00003010, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd7,5'd5,5'd7,  32'h12345678,1'b0};
    tbl[6]  = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b1,5'd9,  5'd9,5'd7,5'd9,  32'h00000000,1'b0};
    tbl[7]  = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd9,5'd5,5'd3,  32'h00000000,1'b1};
    tbl[8]  = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b1,5'd9, 32'h000000A5,4'h1,32'h00003014, 1'b0,5'd0,  5'd9,5'd9,5'd7,  32'h000000A5,1'b0};
    tbl[9]  = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd9,5'd0,5'd9,  32'h000000A5,1'b0};
    tbl[10] = '{1'b0, 1'b1,5'd9, 32'h5A000000,4'h8,32'h00003018, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b1,5'd9,  5'd9,5'd9,5'd9,  32'h5A0000A5,1'b0};
    tbl[11] = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd9,5'd7,5'd5,  32'h5A0000A5,1'b1};
    tbl[12] = '{1'b0, 1'b1,5'd0, 32'hFFFFFFFF,4'hF,32'h0000301C, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b1,5'd0,  5'd0,5'd0,5'd9,  32'h00000000,1'b0};
    tbl[13] = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd0,5'd9,5'd0,  32'h00000000,1'b0};
    tbl[14] = '{1'b0, 1'b1,5'd3, 32'h0,       4'h0,32'h00003020, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd3,5'd3,5'd3,  32'hDEADBEEF,1'b0};
    tbl[15] = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd3, 32'h0,       4'hF,32'h00003024, 1'b0,5'd0,  5'd3,5'd5,5'd7,  32'hDEADBEEF,1'b0};
    tbl[16] = '{1'b0, 1'b1,5'd1, 32'h01010101,4'hF,32'h00003028, 1'b1,5'd2, 32'h02020202,4'hF,32'h0000302C, 1'b0,5'd0,  5'd1,5'd2,5'd9,  32'h01010101,1'b0};
    tbl[17] = '{1'b0, 1'b1,5'd3, 32'h03030303,4'hF,32'h00003030, 1'b1,5'd4, 32'h04040404,4'hF,32'h00003034, 1'b1,5'd6,  5'd4,5'd3,5'd6,  32'h04040404,1'b0};
    tbl[18] = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd6,5'd4,5'd1,  32'h00000000,1'b1};
    tbl[19] = '{1'b1, 1'b1,5'd2, 32'hFFFFFFFF,4'hF,32'h00003038, 1'b1,5'd2, 32'h000000EE,4'h1,32'h0000303C, 1'b1,5'd10, 5'd1,5'd1,5'd1,  32'h01010101,1'b0};
    tbl[20] = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd2,5'd6,5'd4,  32'h00000000,1'b0};
    tbl[21] = '{1'b0, 1'b1,5'd4, 32'hCAFEF00D,4'hF,32'h00003040, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd4,5'd2,5'd9,  32'hCAFEF00D,1'b0};
    tbl[22] = '{1'b0, 1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0, 32'h0,       4'h0,32'h0,       1'b0,5'd0,  5'd9,5'd4,5'd10, 32'h00000000,1'b0};

    // Initial reset with idle inputs: log/collision must read zero after each edge.
    reset = 1'b1;
    we0 = 1'b0; wa0 = 5'd0; wd0 = 32'h0; wbe0 = 4'h0; wpc0 = 32'h0;
    we1 = 1'b0; wa1 = 5'd0; wd1 = 32'h0; wbe1 = 4'h0; wpc1 = 32'h0;
    rsv_en = 1'b0; rsv_addr = 5'd0;
    rd_addr = {5'd3, 5'd2, 5'd1};
    do_cycle(1'b0, 32'h0, 1'b0);
    do_cycle(1'b0, 32'h0, 1'b0);

    // Reset state: all entries and busy bits read zero.
    reset = 1'b0;
    rd_addr = {5'd31, 5'd17, 5'd1};
    do_cycle(1'b1, 32'h0, 1'b0);

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i]);
      do_cycle(1'b1, tbl[i].exp_rd0, tbl[i].exp_b0);
    end

    // Random traffic on a small address range to provoke collisions,
    // bypass hits and reserve/write overlaps.
    for (int i = 0; i < 60; i++) begin
      reset    = 1'b0;
      we0      = 1'($urandom_range(0, 1));
      wa0      = 5'($urandom_range(0, 7));
      wd0      = $urandom;
      wbe0     = 4'($urandom_range(0, 15));
      wpc0     = $urandom;
      we1      = 1'($urandom_range(0, 1));
      wa1      = 5'($urandom_range(0, 7));
      wd1      = $urandom;
      wbe1     = 4'($urandom_range(0, 15));
      wpc1     = $urandom;
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = 5'($urandom_range(0, 7));
      rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      do_cycle(1'b0, 32'h0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
